// File: rtl/sketch_pkg.sv
// Shared types and constants for the etch-a-sketch draw controller.
package sketch_pkg;

    localparam int XW = 10;
    localparam int YW = 9;

    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 480;

    typedef logic [23:0] rgb_t;

    localparam rgb_t DEF_BG_COLOR = 24'hFFFFFF;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        STEP,
        DRAW,
        CLEAR
    } state_t;

endpackage

// File: rtl/sketch_draw_controller_if.sv
// Framebuffer pixel write port: valid/ready handshake carrying one coordinate and colour.
interface sketch_draw_controller_if;
    import sketch_pkg::*;

    logic            wr_valid;
    logic            wr_ready;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;
    rgb_t            wr_data;

    modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);

endinterface

// File: rtl/dial_delta.sv
// Signed movement of one free-running dial counter since the last time it was consumed.
module dial_delta (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        count,
    input  logic              consume,
    input  logic              init,
    output logic signed [7:0] delta
);

    logic [7:0] prev;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else if (init || consume) begin
            prev <= count;
        end
    end

    // Modulo-256 difference read as two's complement gives -128..+127 regardless of wrap.
    assign delta = $signed(count - prev);

endmodule

// File: rtl/sketch_draw_controller.sv
// Turns dial motion into 8-connected cursor steps and pixel writes; sweeps the framebuffer on clear.
module sketch_draw_controller
    import sketch_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   HEIGHT   = DEF_HEIGHT,
    parameter rgb_t BG_COLOR = DEF_BG_COLOR
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [7:0]                leftdial,
    input  logic [7:0]                rightdial,
    input  logic                      clear_btn,
    input  logic                      pen_up,
    input  rgb_t                      pen_color,
    sketch_draw_controller_if.master  wr,
    output logic [XW-1:0]             cursor_x,
    output logic [YW-1:0]             cursor_y,
    output logic                      busy
);

    localparam logic [XW-1:0]        X_MAX  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]        Y_MAX  = YW'(HEIGHT - 1);
    localparam logic [XW-1:0]        X_MID  = XW'(WIDTH / 2);
    localparam logic [YW-1:0]        Y_MID  = YW'(HEIGHT / 2);
    localparam logic signed [XW+1:0] SX_MAX = (XW+2)'(WIDTH - 1);
    localparam logic signed [YW+1:0] SY_MAX = (YW+2)'(HEIGHT - 1);

    state_t                state;
    logic signed [7:0]     dx, dy;
    logic signed [XW+1:0]  sum_x;
    logic signed [YW+1:0]  sum_y;
    logic [XW-1:0]         clamp_x, next_x, target_x;
    logic [YW-1:0]         clamp_y, next_y, target_y;
    logic                  consume, clear_q, clear_pending, clear_rise;
    logic                  transfer, at_target, start_clear;
    logic                  wv;
    logic [XW-1:0]         wx;
    logic [YW-1:0]         wy;
    rgb_t                  wd;

    dial_delta u_left  (.clk(clk_clk), .rst(reset_reset), .count(leftdial),
                        .consume(consume), .init(state == INIT), .delta(dx));
    dial_delta u_right (.clk(clk_clk), .rst(reset_reset), .count(rightdial),
                        .consume(consume), .init(state == INIT), .delta(dy));

    assign sum_x = $signed({2'b00, cursor_x}) + $signed({{(XW-6){dx[7]}}, dx});
    assign sum_y = $signed({2'b00, cursor_y}) + $signed({{(YW-6){dy[7]}}, dy});

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        clamp_x = sum_x[XW-1:0];
        if (sum_x[XW+1])        clamp_x = '0;
        else if (sum_x > SX_MAX) clamp_x = X_MAX;
        clamp_y = sum_y[YW-1:0];
        if (sum_y[YW+1])        clamp_y = '0;
        else if (sum_y > SY_MAX) clamp_y = Y_MAX;
    end

    always_comb begin
        next_x = cursor_x;
        if (cursor_x < target_x)      next_x = cursor_x + XW'(1);
        else if (cursor_x > target_x) next_x = cursor_x - XW'(1);
        next_y = cursor_y;
        if (cursor_y < target_y)      next_y = cursor_y + YW'(1);
        else if (cursor_y > target_y) next_y = cursor_y - YW'(1);
    end

    assign consume     = (state == IDLE) && !clear_pending && ((dx != 8'sd0) || (dy != 8'sd0));
    assign transfer    = wv && wr.wr_ready;
    assign at_target   = (cursor_x == target_x) && (cursor_y == target_y);
    assign clear_rise  = clear_btn && !clear_q;
    assign start_clear = clear_pending &&
                         ((state == IDLE) || ((state == DRAW) && transfer && at_target));

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state         <= INIT;
            cursor_x      <= X_MID;
            cursor_y      <= Y_MID;
            target_x      <= X_MID;
            target_y      <= Y_MID;
            clear_q       <= 1'b0;
            clear_pending <= 1'b0;
            wv            <= 1'b0;
            wx            <= '0;
            wy            <= '0;
            wd            <= '0;
        end else begin
            clear_q <= clear_btn;
            if (start_clear)                         clear_pending <= 1'b0;
            else if (clear_rise && state != CLEAR)   clear_pending <= 1'b1;

            case (state)
                INIT: state <= IDLE;
                IDLE: begin
                    if (consume && (clamp_x != cursor_x || clamp_y != cursor_y)) begin
                        target_x <= clamp_x;
                        target_y <= clamp_y;
                        state    <= STEP;
                    end
                end
                STEP: begin
                    cursor_x <= next_x;
                    cursor_y <= next_y;
                    if (!pen_up) begin
                        wv    <= 1'b1;
                        wx    <= next_x;
                        wy    <= next_y;
                        wd    <= pen_color;
                        state <= DRAW;
                    end else if (next_x == target_x && next_y == target_y) begin
                        state <= IDLE;
                    end
                end
                DRAW: begin
                    if (transfer) begin
                        wv    <= 1'b0;
                        state <= at_target ? IDLE : STEP;
                    end
                end
                CLEAR: begin
                    if (transfer) begin
                        if (wx != X_MAX) begin
                            wx <= wx + XW'(1);
                        end else if (wy != Y_MAX) begin
                            wx <= '0;
                            wy <= wy + YW'(1);
                        end else begin
                            wv    <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= INIT;
            endcase

            // Entering CLEAR overrides the IDLE/DRAW decisions above and presents pixel (0,0).
            if (start_clear) begin
                state <= CLEAR;
                wv    <= 1'b1;
                wx    <= '0;
                wy    <= '0;
                wd    <= BG_COLOR;
            end
        end
    end

    assign wr.wr_valid = wv;
    assign wr.wr_x     = wx;
    assign wr.wr_y     = wy;
    assign wr.wr_data  = wd;
    assign busy        = (state == STEP) || (state == DRAW) || (state == CLEAR);

endmodule

// File: tb/tb_sketch_draw_controller.sv
// Directed bench: full-size instance for motion/clamp/handshake, 16x8 instance for complete clear sweeps.
module tb_sketch_draw_controller;
    import sketch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] leftdial = 8'h00, rightdial = 8'h00;
    logic       clear_btn = 1'b0, pen_up = 1'b0, ready = 1'b1;
    rgb_t       pen_color = '0;

    logic [XW-1:0] cx_b, cx_s;
    logic [YW-1:0] cy_b, cy_s;
    logic          busy_b, busy_s;

    sketch_draw_controller_if wb ();
    sketch_draw_controller_if ws ();
    assign wb.wr_ready = ready;
    assign ws.wr_ready = ready;

    sketch_draw_controller dut_b (
        .clk_clk(clk), .reset_reset(rst), .leftdial(leftdial), .rightdial(rightdial),
        .clear_btn(clear_btn), .pen_up(pen_up), .pen_color(pen_color), .wr(wb.master),
        .cursor_x(cx_b), .cursor_y(cy_b), .busy(busy_b)
    );

    sketch_draw_controller #(.WIDTH(16), .HEIGHT(8)) dut_s (
        .clk_clk(clk), .reset_reset(rst), .leftdial(leftdial), .rightdial(rightdial),
        .clear_btn(clear_btn), .pen_up(pen_up), .pen_color(pen_color), .wr(ws.master),
        .cursor_x(cx_s), .cursor_y(cy_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] l, input logic [7:0] r);
        @(negedge clk);
        leftdial  = l;
        rightdial = r;
        clear_btn = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic bit adjacent(input int ax, input int ay, input int bx, input int by);
        int ddx, ddy;
        ddx = bx - ax;
        ddy = by - ay;
        return (ddx >= -1) && (ddx <= 1) && (ddy >= -1) && (ddy <= 1) && !(ddx == 0 && ddy == 0);
    endfunction

    typedef struct {
        bit         rst;
        logic [7:0] pre_l, pre_r, left, right;
        bit         pen;
        rgb_t       color;
        int         n, fx, fy, lx, ly, cx, cy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        vec_t v;
        int   nw, bad_step, bad_data, px, py, mx, my, fx, fy, lx, ly, bad;
        bit   done, saw_valid, saw_busy;
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        rgb_t hd;
        int   wxs[$], wys[$], tcs[$];
        rgb_t wds[$];
        bit   bz [400];

        //         rst   pre_l  pre_r  left   right  pen   color        n  fx   fy   lx   ly   cx   cy
        vecs[0]  = '{1'b1, 8'h10, 8'h02, 8'h13, 8'h02, 1'b0, 24'h00FF00, 3, 401, 240, 403, 240, 403, 240};
        vecs[1]  = '{1'b1, 8'hFE, 8'h02, 8'h02, 8'hFE, 1'b0, 24'h123456, 4, 401, 239, 404, 236, 404, 236};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 24'hABCDEF, 3, 403, 237, 402, 239, 402, 239};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 407, 239};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h84, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 534, 239};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h03, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 661, 239};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h82, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 788, 239};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h8C, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 798, 239};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'h96, 8'h01, 1'b0, 24'hFF0000, 1, 799, 239, 799, 239, 799, 239};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h9B, 8'h01, 1'b0, 24'hFF0000, 0, 0, 0, 0, 0, 799, 239};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h9B, 8'h81, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 799, 111};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h9B, 8'h01, 1'b1, 24'h000000, 0, 0, 0, 0, 0, 799, 0};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h9B, 8'hFF, 1'b0, 24'h00FFFF, 0, 0, 0, 0, 0, 799, 0};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 8'h9D, 8'h01, 1'b0, 24'h00FFFF, 2, 799, 1, 799, 2, 799, 2};
        vecs[14] = '{1'b0, 8'h00, 8'h00, 8'h9A, 8'h02, 1'b0, 24'h0F0F0F, 3, 798, 3, 796, 3, 796, 3};

        // Reset state, then 20 idle cycles with static dials.
        do_reset(8'h00, 8'h00);
        check("rst_wr_x", wb.wr_x, 0);
        check("rst_wr_y", wb.wr_y, 0);
        check("rst_wr_data", wb.wr_data, 0);
        saw_valid = 0;
        saw_busy  = 0;
        repeat (20) begin
            @(negedge clk);
            saw_valid |= wb.wr_valid;
            saw_busy  |= busy_b;
        end
        check("idle_cursor_x", cx_b, 400);
        check("idle_cursor_y", cy_b, 240);
        check("idle_no_valid", saw_valid, 0);
        check("idle_no_busy", saw_busy, 0);

        // Latency n+2 and five cycles of backpressure with a stable request.
        do_reset(8'h40, 8'h40);
        ready     = 1'b0;
        pen_up    = 1'b0;
        pen_color = 24'hC0FFEE;
        leftdial  = 8'h41;
        @(negedge clk);
        check("lat_n1_busy", busy_b, 1);
        check("lat_n1_valid", wb.wr_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", wb.wr_valid, 1);
        check("lat_n2_x", wb.wr_x, 401);
        check("lat_n2_y", wb.wr_y, 240);
        check("lat_n2_data", wb.wr_data, 24'hC0FFEE);
        hx = wb.wr_x; hy = wb.wr_y; hd = wb.wr_data;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (!wb.wr_valid || wb.wr_x != hx || wb.wr_y != hy || wb.wr_data != hd) bad++;
        end
        check("bp_stable", bad, 0);
        ready = 1'b1;
        @(negedge clk);
        check("bp_after_valid", wb.wr_valid, 0);
        check("bp_after_busy", busy_b, 0);
        check("bp_after_cursor_x", cx_b, 401);

        // Table of moves on the full-size instance.
        mx = 400;
        my = 240;
        fx = 0; fy = 0; lx = 0; ly = 0;
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            if (v.rst) begin
                do_reset(v.pre_l, v.pre_r);
                mx = 400;
                my = 240;
            end
            pen_up    = v.pen;
            pen_color = v.color;
            leftdial  = v.left;
            rightdial = v.right;
            nw = 0; bad_step = 0; bad_data = 0; px = mx; py = my; done = 0;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge clk);
                if (wb.wr_valid && ready) begin
                    if (nw == 0) begin fx = int'(wb.wr_x); fy = int'(wb.wr_y); end
                    lx = int'(wb.wr_x);
                    ly = int'(wb.wr_y);
                    if (!adjacent(px, py, lx, ly)) bad_step++;
                    if (wb.wr_data != v.color) bad_data++;
                    px = lx;
                    py = ly;
                    nw++;
                end
                if (!busy_b) done = 1;
            end
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_nwrites", i), nw, v.n);
            if (v.n > 0) begin
                check($sformatf("v%0d_first", i), {fx, fy}, {v.fx, v.fy});
                check($sformatf("v%0d_last", i), {lx, ly}, {v.lx, v.ly});
                check($sformatf("v%0d_8conn", i), bad_step, 0);
                check($sformatf("v%0d_data", i), bad_data, 0);
            end
            check($sformatf("v%0d_cursor", i), {int'(cx_b), int'(cy_b)}, {v.cx, v.cy});
            mx = v.cx;
            my = v.cy;
        end

        // Pen up: one step per cycle, no writes.
        do_reset(8'h00, 8'h00);
        pen_up   = 1'b1;
        leftdial = 8'h05;
        saw_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            saw_valid |= wb.wr_valid;
            if (k >= 2) begin
                check($sformatf("penup_k%0d_x", k), cx_b, 400 + k - 1);
                check($sformatf("penup_k%0d_busy", k), busy_b, (k < 6));
            end
        end
        check("penup_no_valid", saw_valid, 0);

        // Clear requested mid-move on the 16x8 instance; dial motion and a second request during the sweep.
        do_reset(8'h20, 8'h20);
        pen_up    = 1'b0;
        pen_color = 24'h0000FF;
        leftdial  = 8'h23;
        for (int c = 0; c < 400; c++) begin
            if (c == 1)  clear_btn = 1'b1;
            if (c == 2)  clear_btn = 1'b0;
            if (c == 60) rightdial = 8'h22;
            if (c == 70) clear_btn = 1'b1;
            if (c == 71) clear_btn = 1'b0;
            @(negedge clk);
            bz[c] = busy_s;
            if (ws.wr_valid && ready) begin
                wxs.push_back(int'(ws.wr_x));
                wys.push_back(int'(ws.wr_y));
                wds.push_back(ws.wr_data);
                tcs.push_back(c);
            end
        end
        check("clr_nwrites", wxs.size(), 133);
        if (wxs.size() == 133) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("clr_move%0d", k), {wxs[k], wys[k], 8'h0, wds[k]}, {9 + k, 4, 8'h0, 24'h0000FF});
            check("clr_first", {wxs[3], wys[3], 8'h0, wds[3]}, {0, 0, 8'h0, 24'hFFFFFF});
            check("clr_last", {wxs[130], wys[130], 8'h0, wds[130]}, {15, 7, 8'h0, 24'hFFFFFF});
            bad = 0;
            for (int k = 0; k < 128; k++)
                if (wxs[3+k] != k % 16 || wys[3+k] != k / 16 || wds[3+k] != 24'hFFFFFF) bad++;
            check("clr_row_major", bad, 0);
            check("clr_busy_last", bz[tcs[130]], 1);
            check("clr_busy_fall", bz[tcs[130] + 1], 0);
            check("post_clr_w0", {wxs[131], wys[131], 8'h0, wds[131]}, {11, 5, 8'h0, 24'h0000FF});
            check("post_clr_w1", {wxs[132], wys[132], 8'h0, wds[132]}, {11, 6, 8'h0, 24'h0000FF});
        end
        check("clr_cursor", {int'(cx_s), int'(cy_s)}, {11, 6});

        // Reset asserted in the middle of a clear sweep.
        clear_btn = 1'b1;
        @(negedge clk);
        clear_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("midclr_busy_s", busy_s, 1);
        check("midclr_valid_s", ws.wr_valid, 1);
        check("midclr_valid_b", wb.wr_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_valid_s", ws.wr_valid, 0);
        check("async_valid_b", wb.wr_valid, 0);
        check("async_busy_b", busy_b, 0);
        check("async_cursor_b", {int'(cx_b), int'(cy_b)}, {400, 240});
        check("async_cursor_s", {int'(cx_s), int'(cy_s)}, {8, 4});
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule
